prio_arbiter: RTL and testbench

Four-requester resource arbiter that shares a single downstream resource (bus, datapath port) among requesters `req[3:0]`. The 4-input priority encoding rule (bit 3 highest) decides each grant. The arbiter holds a grant while the owner keeps requesting and forces re-arbitration after a configurable hold limit. Grants are registered, one-hot, and accompanied by an encoded owner ID.

---
 rtl/arb_pkg.sv | 24 ++
 rtl/prio_arbiter_if.sv | 33 +++
 rtl/prio_enc4.sv | 24 ++
 rtl/prio_arbiter.sv | 144 ++++++++++++++
 tb/tb_prio_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | arb_pkg : shared types, sizes and helpers for the prio_arbiter block  |
// | Rev 1.0 : initial release                                              |
// +-----------------------------------------------------------------------+
package arb_pkg;

   localparam int unsigned NREQ = 4;
   localparam int unsigned ID_W = 2;

   typedef enum logic [0:0] {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_t;

   function automatic logic [NREQ-1:0] onehot(input logic [ID_W-1:0] id);
      logic [NREQ-1:0] v;
      v     = '0;
      v[id] = 1'b1;
      return v;
   endfunction

endpackage : arb_pkg
`default_nettype wire

// File: rtl/prio_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | prio_arbiter_if : request/grant bundle between requesters and arbiter |
// | Rev 1.0 : initial release                                              |
// +-----------------------------------------------------------------------+
interface prio_arbiter_if;
   import arb_pkg::*;

   logic [NREQ-1:0] req;
   logic [NREQ-1:0] gnt;
   logic [ID_W-1:0] gnt_id;
   logic            gnt_valid;
   logic            hold_exp;

   // master = requester side, slave = arbiter side
   modport master (
      output req,
      input  gnt,
      input  gnt_id,
      input  gnt_valid,
      input  hold_exp
   );

   modport slave (
      input  req,
      output gnt,
      output gnt_id,
      output gnt_valid,
      output hold_exp
   );

endinterface : prio_arbiter_if
`default_nettype wire

// File: rtl/prio_enc4.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | prio_enc4 : combinational 4-to-2 priority encoder, bit 3 highest       |
// | Rev 1.0 : initial release                                              |
// +-----------------------------------------------------------------------+
module prio_enc4
   import arb_pkg::*;
(
   input  wire logic [NREQ-1:0] req,
   output logic      [ID_W-1:0] id,
   output logic                 valid
);

   always_comb begin
      id    = '0;
      valid = |req;
      if (req[3])      id = 2'd3;
      else if (req[2]) id = 2'd2;
      else if (req[1]) id = 2'd1;
      else             id = 2'd0;
   end

endmodule : prio_enc4
`default_nettype wire

// File: rtl/prio_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | prio_arbiter : 4-requester arbiter with registered one-hot grant and  |
// |                per-owner hold limit. Optional macro ARB_ROUND_ROBIN_EN |
// |                selects rotating priority instead of fixed 3>2>1>0.     |
// | Rev 1.0 : initial release                                              |
// +-----------------------------------------------------------------------+
module prio_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned HOLD_MAX = 8
) (
   input  wire logic     clk,
   input  wire logic     rst,
   prio_arbiter_if.slave bus
);

   localparam int unsigned      CNT_W    = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
   localparam logic             HOLD_EN  = (HOLD_MAX != 0);

   arb_state_t      state;
   arb_state_t      next_state;
   logic [ID_W-1:0] owner_id;
   logic [ID_W-1:0] next_id;
   logic [CNT_W-1:0] hold_cnt;
   logic [CNT_W-1:0] next_cnt;
   logic            hold_pulse;
   logic            next_pulse;
   logic            new_grant;

   logic            owner_req;
   logic            expire;
   logic [NREQ-1:0] cand;
   logic [NREQ-1:0] enc_in;
   logic [ID_W-1:0] enc_id;
   logic            win_valid;
   logic [ID_W-1:0] win_id;

   // On expiry the owner is masked so any other requester gets a turn
   always_comb begin
      owner_req = bus.req[owner_id];
      expire    = HOLD_EN && (state == ARB_GRANT) && owner_req && (hold_cnt == CNT_LAST);
      cand      = expire ? (bus.req & ~onehot(owner_id)) : bus.req;
   end

`ifdef ARB_ROUND_ROBIN_EN
   logic [ID_W-1:0] last_id;
   logic [ID_W-1:0] src;

   // Rotate so the requester just below last_id lands on bit 3
   always_comb begin
      enc_in = '0;
      src    = '0;
      for (int j = 0; j < NREQ; j++) begin
         src       = ID_W'(j) + last_id;
         enc_in[j] = cand[src];
      end
   end

   assign win_id = enc_id + last_id;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)            last_id <= ID_W'(NREQ - 1);
      else if (new_grant) last_id <= next_id;
   end
`else
   assign enc_in = cand;
   assign win_id = enc_id;
`endif

   prio_enc4 u_enc (
      .req   (enc_in),
      .id    (enc_id),
      .valid (win_valid)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ARB_IDLE;
         owner_id   <= '0;
         hold_cnt   <= '0;
         hold_pulse <= 1'b0;
      end else begin
         state      <= next_state;
         owner_id   <= next_id;
         hold_cnt   <= next_cnt;
         hold_pulse <= next_pulse;
      end
   end

   always_comb begin
      next_state = state;
      next_id    = owner_id;
      next_cnt   = hold_cnt;
      next_pulse = 1'b0;
      new_grant  = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (win_valid) begin
               next_state = ARB_GRANT;
               next_id    = win_id;
               next_cnt   = '0;
               new_grant  = 1'b1;
            end
         end
         ARB_GRANT: begin
            if (!owner_req) begin
               next_cnt = '0;
               if (win_valid) begin
                  next_id   = win_id;
                  new_grant = 1'b1;
               end else begin
                  next_state = ARB_IDLE;
               end
            end else if (expire) begin
               // Uncontended expiry keeps the owner and silently restarts the count
               next_cnt = '0;
               if (win_valid) begin
                  next_id    = win_id;
                  next_pulse = 1'b1;
                  new_grant  = 1'b1;
               end
            end else if (hold_cnt != CNT_SAT) begin
               next_cnt = hold_cnt + CNT_W'(1);
            end
         end
         default: next_state = ARB_IDLE;
      endcase
   end

   logic grant_on;

   always_comb begin
      grant_on      = (state == ARB_GRANT);
      bus.gnt_valid = grant_on;
      bus.gnt_id    = owner_id;
      bus.gnt       = grant_on ? onehot(owner_id) : '0;
      bus.hold_exp  = hold_pulse;
   end

endmodule : prio_arbiter
`default_nettype wire

// File: tb/tb_prio_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_prio_arbiter : directed scenarios plus randomized run vs a model   |
// | Rev 1.0 : initial release                                              |
// +-----------------------------------------------------------------------+
module tb_prio_arbiter;
   import arb_pkg::*;

   localparam int HM = 8;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   prio_arbiter_if bus ();

   prio_arbiter #(.HOLD_MAX(HM)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // reference model state, in terms of owners and cycle counts
   bit m_valid;
   int m_owner;
   int m_cnt;
   int m_last;
   bit m_exp;

   task automatic tick(input logic [3:0] r);
      @(negedge clk);
      bus.req = r;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.req = 4'b0000;
      rst     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic int pick(input logic [3:0] r, input int excl, input int last);
`ifdef ARB_ROUND_ROBIN_EN
      for (int k = 1; k <= 4; k++) begin
         int idx = (last - k + 8) % 4;
         if (r[idx] && idx != excl) return idx;
      end
`else
      for (int i = 3; i >= 0; i--)
         if (r[i] && i != excl) return i;
`endif
      return -1;
   endfunction

   task automatic model_step(input logic [3:0] r);
      int w;
      m_exp = 1'b0;
      if (!m_valid) begin
         w = pick(r, -1, m_last);
         if (w >= 0) begin m_valid = 1'b1; m_owner = w; m_cnt = 0; m_last = w; end
      end else if (!r[m_owner]) begin
         w = pick(r, -1, m_last);
         if (w >= 0) begin m_owner = w; m_cnt = 0; m_last = w; end
         else m_valid = 1'b0;
      end else if (HM != 0 && m_cnt == HM - 1) begin
         w = pick(r, m_owner, m_last);
         m_cnt = 0;
         if (w >= 0) begin m_owner = w; m_exp = 1'b1; m_last = w; end
      end else begin
         m_cnt++;
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks += 4;
      if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b want=0000", bus.gnt); end
      if (bus.gnt_id !== 2'b00) begin failures++; $display("FAIL reset_gnt_id got=%0d want=0", bus.gnt_id); end
      if (bus.gnt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", bus.gnt_valid); end
      if (bus.hold_exp !== 1'b0) begin failures++; $display("FAIL reset_hold_exp got=%b want=0", bus.hold_exp); end
   endtask

   task automatic test_single();
      tick(4'b0100);
      checks += 3;
      if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL single_gnt got=%b want=0100", bus.gnt); end
      if (bus.gnt_id !== 2'd2) begin failures++; $display("FAIL single_id got=%0d want=2", bus.gnt_id); end
      if (bus.gnt_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b want=1", bus.gnt_valid); end
      tick(4'b0000);
      checks += 2;
      if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL single_release got=%b want=0000", bus.gnt); end
      if (bus.gnt_valid !== 1'b0) begin failures++; $display("FAIL single_release_valid got=%b want=0", bus.gnt_valid); end
   endtask

   task automatic test_contention();
      logic [3:0] reqs [3] = '{4'b1011, 4'b0011, 4'b0001};
      logic [3:0] want [3] = '{4'b1000, 4'b0010, 4'b0001};
      for (int i = 0; i < 3; i++) begin
         tick(reqs[i]);
         checks++;
         if (bus.gnt !== want[i]) begin
            failures++;
            $display("FAIL contention step %0d got=%b want=%b", i, bus.gnt, want[i]);
         end
      end
      tick(4'b0000);
   endtask

   task automatic test_hold_expiry();
      logic [3:0] want;
      logic       want_exp;
      for (int c = 0; c < 3 * HM; c++) begin
         tick(4'b1001);
         want     = ((c / HM) % 2 == 0) ? 4'b1000 : 4'b0001;
         want_exp = (c != 0) && (c % HM == 0);
         checks++;
         if (bus.gnt !== want || bus.hold_exp !== want_exp) begin
            failures++;
            $display("FAIL hold_expiry cycle %0d got gnt=%b exp=%b want gnt=%b exp=%b",
                     c, bus.gnt, bus.hold_exp, want, want_exp);
         end
      end
      tick(4'b0000);
   endtask

   task automatic test_uncontended();
      int bad = 0;
      for (int c = 0; c < 20; c++) begin
         tick(4'b0010);
         checks++;
         if (bus.gnt !== 4'b0010 || bus.hold_exp !== 1'b0) begin
            failures++;
            $display("FAIL uncontended cycle %0d got gnt=%b exp=%b want gnt=0010 exp=0",
                     c, bus.gnt, bus.hold_exp);
         end
      end
      tick(4'b0000);
   endtask

   task automatic test_async_reset();
      tick(4'b0100);
      checks++;
      if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL async_pre got=%b want=0100", bus.gnt); end
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks += 2;
      if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL async_gnt got=%b want=0000", bus.gnt); end
      if (bus.gnt_valid !== 1'b0) begin failures++; $display("FAIL async_valid got=%b want=0", bus.gnt_valid); end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL async_regrant got=%b want=0100", bus.gnt); end
      tick(4'b0000);
   endtask

`ifdef ARB_ROUND_ROBIN_EN
   task automatic test_round_robin();
      int         want [5] = '{2, 1, 0, 3, 2};
      logic [3:0] r;
      do_reset();
      r = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         tick(r);
         checks++;
         if (bus.gnt_id !== 2'(want[i]) || bus.gnt_valid !== 1'b1) begin
            failures++;
            $display("FAIL round_robin step %0d got id=%0d v=%b want id=%0d", i, bus.gnt_id, bus.gnt_valid, want[i]);
         end
         r = 4'b1111 & ~(4'b0001 << want[i]);
      end
      tick(4'b0000);
   endtask
`endif

   task automatic test_random();
      logic [3:0] r = 4'b0000;
      logic [3:0] eg;
      do_reset();
      m_valid = 1'b0; m_owner = 0; m_cnt = 0; m_last = 3; m_exp = 1'b0;
      for (int c = 0; c < 600; c++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
         model_step(r);
         tick(r);
         eg = m_valid ? 4'(1 << m_owner) : 4'b0000;
         checks++;
         if (bus.gnt !== eg || bus.gnt_valid !== m_valid || bus.hold_exp !== m_exp ||
             (m_valid && bus.gnt_id !== 2'(m_owner))) begin
            failures++;
            $display("FAIL random cycle %0d req=%b got gnt=%b id=%0d v=%b exp=%b want gnt=%b id=%0d v=%b exp=%b",
                     c, r, bus.gnt, bus.gnt_id, bus.gnt_valid, bus.hold_exp, eg, m_owner, m_valid, m_exp);
         end
      end
      tick(4'b0000);
   endtask

   initial begin
      rst     = 1'b1;
      bus.req = 4'b0000;
      test_reset();
      test_single();
`ifndef ARB_ROUND_ROBIN_EN
      test_contention();
      test_hold_expiry();
`endif
      test_uncontended();
      test_async_reset();
`ifdef ARB_ROUND_ROBIN_EN
      test_round_robin();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule : tb_prio_arbiter
`default_nettype wire
